// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus arbiter in front of the ROB result-write port. Each of the
// three completion sources (ALU, LOAD, STORE-address) owns one holding slot.
// One occupied slot is granted per cycle and broadcast through a registered
// CDB output. The grant order is round-robin by default.
//
// Optional feature macro: CDB_FIXED_PRIORITY_EN
//   defined   -> fixed priority LOAD > ALU > STORE, rr pointer held at 0
//   undefined -> round-robin starting at rr, rr+1, rr+2 (mod 3)
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   rdy_in                  global advance; low freezes all state
//   roll_back               synchronous flush of slots and broadcast
//   alu_valid/ready/entry/result/pc_result   ALU completion handshake
//   ld_valid/ready/entry/result              LOAD completion handshake
//   st_valid/ready/entry                     STORE address completion
//   cdb_valid/src/entry/result/pc_result     registered broadcast
//   cdb_pending             popcount of occupied slots (combinational)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int unsigned ENTRY_W = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,

    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [ENTRY_W-1:0] alu_entry,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  alu_pc_result,

    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ENTRY_W-1:0] ld_entry,
    input  logic [DATA_W-1:0]  ld_result,

    input  logic               st_valid,
    output logic               st_ready,
    input  logic [ENTRY_W-1:0] st_entry,

    output logic               cdb_valid,
    output logic [1:0]         cdb_src,
    output logic [ENTRY_W-1:0] cdb_entry,
    output logic [DATA_W-1:0]  cdb_result,
    output logic [DATA_W-1:0]  cdb_pc_result,
    output logic [1:0]         cdb_pending
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_LD  = 2'd1;
    localparam logic [1:0] SRC_ST  = 2'd2;

    // One-hot grant vector: bit0 ALU, bit1 LOAD, bit2 STORE
    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_ALU  = 3'b001;
    localparam logic [2:0] GNT_LD   = 3'b010;
    localparam logic [2:0] GNT_ST   = 3'b100;

    typedef enum logic [1:0] {
        RR_ALU = 2'd0,
        RR_LD  = 2'd1,
        RR_ST  = 2'd2
    } rr_e;

    // Holding slots
    logic               r_alu_v;
    logic [ENTRY_W-1:0] r_alu_tag;
    logic [DATA_W-1:0]  r_alu_data;
    logic [DATA_W-1:0]  r_alu_pc;
    logic               r_ld_v;
    logic [ENTRY_W-1:0] r_ld_tag;
    logic [DATA_W-1:0]  r_ld_data;
    logic               r_st_v;
    logic [ENTRY_W-1:0] r_st_tag;
    rr_e                r_rr;

    // Next-state values
    logic               w_alu_v_nxt;
    logic [ENTRY_W-1:0] w_alu_tag_nxt;
    logic [DATA_W-1:0]  w_alu_data_nxt;
    logic [DATA_W-1:0]  w_alu_pc_nxt;
    logic               w_ld_v_nxt;
    logic [ENTRY_W-1:0] w_ld_tag_nxt;
    logic [DATA_W-1:0]  w_ld_data_nxt;
    logic               w_st_v_nxt;
    logic [ENTRY_W-1:0] w_st_tag_nxt;
    rr_e                w_rr_nxt;
    logic               w_cdb_valid_nxt;
    logic [1:0]         w_cdb_src_nxt;
    logic [ENTRY_W-1:0] w_cdb_entry_nxt;
    logic [DATA_W-1:0]  w_cdb_result_nxt;
    logic [DATA_W-1:0]  w_cdb_pc_nxt;

    logic               w_adv;
    logic [2:0]         w_gnt;
    rr_e                w_rr_win;
    logic               w_alu_acc;
    logic               w_ld_acc;
    logic               w_st_acc;

    // The pipeline only moves when enabled and not being flushed
    assign w_adv = rdy_in && !roll_back;

    // Grant selection over the holding slots only; new arrivals wait a cycle
    always_comb begin
        w_gnt    = GNT_NONE;
        w_rr_win = RR_ALU;
`ifdef CDB_FIXED_PRIORITY_EN
        if (r_ld_v) begin
            w_gnt = GNT_LD;
        end else if (r_alu_v) begin
            w_gnt = GNT_ALU;
        end else if (r_st_v) begin
            w_gnt = GNT_ST;
        end
`else
        case (r_rr)
            RR_LD: begin
                if (r_ld_v)       w_gnt = GNT_LD;
                else if (r_st_v)  w_gnt = GNT_ST;
                else if (r_alu_v) w_gnt = GNT_ALU;
            end
            RR_ST: begin
                if (r_st_v)       w_gnt = GNT_ST;
                else if (r_alu_v) w_gnt = GNT_ALU;
                else if (r_ld_v)  w_gnt = GNT_LD;
            end
            default: begin
                if (r_alu_v)      w_gnt = GNT_ALU;
                else if (r_ld_v)  w_gnt = GNT_LD;
                else if (r_st_v)  w_gnt = GNT_ST;
            end
        endcase
        // Pointer moves to the source after the winner
        case (w_gnt)
            GNT_ALU: w_rr_win = RR_LD;
            GNT_LD:  w_rr_win = RR_ST;
            default: w_rr_win = RR_ALU;
        endcase
`endif
    end

    // A slot can accept when empty or when it is being drained this cycle
    assign alu_ready = w_adv && (!r_alu_v || w_gnt[0]);
    assign ld_ready  = w_adv && (!r_ld_v  || w_gnt[1]);
    assign st_ready  = w_adv && (!r_st_v  || w_gnt[2]);

    assign w_alu_acc = alu_valid && alu_ready;
    assign w_ld_acc  = ld_valid  && ld_ready;
    assign w_st_acc  = st_valid  && st_ready;

    assign cdb_pending = 2'(r_alu_v) + 2'(r_ld_v) + 2'(r_st_v);

    // Next-state: flush outranks freeze, freeze outranks grant/accept
    always_comb begin
        w_alu_v_nxt      = r_alu_v;
        w_alu_tag_nxt    = r_alu_tag;
        w_alu_data_nxt   = r_alu_data;
        w_alu_pc_nxt     = r_alu_pc;
        w_ld_v_nxt       = r_ld_v;
        w_ld_tag_nxt     = r_ld_tag;
        w_ld_data_nxt    = r_ld_data;
        w_st_v_nxt       = r_st_v;
        w_st_tag_nxt     = r_st_tag;
        w_rr_nxt         = r_rr;
        w_cdb_valid_nxt  = cdb_valid;
        w_cdb_src_nxt    = cdb_src;
        w_cdb_entry_nxt  = cdb_entry;
        w_cdb_result_nxt = cdb_result;
        w_cdb_pc_nxt     = cdb_pc_result;

        if (roll_back) begin
            w_alu_v_nxt     = 1'b0;
            w_ld_v_nxt      = 1'b0;
            w_st_v_nxt      = 1'b0;
            w_cdb_valid_nxt = 1'b0;
            w_rr_nxt        = RR_ALU;
        end else if (rdy_in) begin
            w_cdb_valid_nxt = |w_gnt;
            if (|w_gnt) begin
                w_rr_nxt = w_rr_win;
            end

            if (w_gnt[0]) begin
                w_cdb_src_nxt    = SRC_ALU;
                w_cdb_entry_nxt  = r_alu_tag;
                w_cdb_result_nxt = r_alu_data;
                w_cdb_pc_nxt     = r_alu_pc;
                w_alu_v_nxt      = 1'b0;
            end else if (w_gnt[1]) begin
                w_cdb_src_nxt    = SRC_LD;
                w_cdb_entry_nxt  = r_ld_tag;
                w_cdb_result_nxt = r_ld_data;
                w_cdb_pc_nxt     = '0;
                w_ld_v_nxt       = 1'b0;
            end else if (w_gnt[2]) begin
                w_cdb_src_nxt    = SRC_ST;
                w_cdb_entry_nxt  = r_st_tag;
                w_cdb_result_nxt = '0;
                w_cdb_pc_nxt     = '0;
                w_st_v_nxt       = 1'b0;
            end

            // Refill after the clear so a same-cycle refill wins
            if (w_alu_acc) begin
                w_alu_v_nxt    = 1'b1;
                w_alu_tag_nxt  = alu_entry;
                w_alu_data_nxt = alu_result;
                w_alu_pc_nxt   = alu_pc_result;
            end
            if (w_ld_acc) begin
                w_ld_v_nxt    = 1'b1;
                w_ld_tag_nxt  = ld_entry;
                w_ld_data_nxt = ld_result;
            end
            if (w_st_acc) begin
                w_st_v_nxt   = 1'b1;
                w_st_tag_nxt = st_entry;
            end
        end
    end

    // State and broadcast registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_alu_v       <= 1'b0;
            r_alu_tag     <= '0;
            r_alu_data    <= '0;
            r_alu_pc      <= '0;
            r_ld_v        <= 1'b0;
            r_ld_tag      <= '0;
            r_ld_data     <= '0;
            r_st_v        <= 1'b0;
            r_st_tag      <= '0;
            r_rr          <= RR_ALU;
            cdb_valid     <= 1'b0;
            cdb_src       <= SRC_ALU;
            cdb_entry     <= '0;
            cdb_result    <= '0;
            cdb_pc_result <= '0;
        end else begin
            r_alu_v       <= w_alu_v_nxt;
            r_alu_tag     <= w_alu_tag_nxt;
            r_alu_data    <= w_alu_data_nxt;
            r_alu_pc      <= w_alu_pc_nxt;
            r_ld_v        <= w_ld_v_nxt;
            r_ld_tag      <= w_ld_tag_nxt;
            r_ld_data     <= w_ld_data_nxt;
            r_st_v        <= w_st_v_nxt;
            r_st_tag      <= w_st_tag_nxt;
            r_rr          <= w_rr_nxt;
            cdb_valid     <= w_cdb_valid_nxt;
            cdb_src       <= w_cdb_src_nxt;
            cdb_entry     <= w_cdb_entry_nxt;
            cdb_result    <= w_cdb_result_nxt;
            cdb_pc_result <= w_cdb_pc_nxt;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter placed in front of the reorder buffer's single result-write port. The ALU reservation station, load broadcast and store-address completion each currently drive their own ROB update path. This block buffers one completion per source and grants one completion per cycle, round-robin. It outputs a single registered broadcast (valid, entry, result, pc_result, source tag) that the ROB and the operand-forwarding logic consume.

## Interface
Parameters:
- ENTRY_W, 5, ROB entry tag width (32-entry ROB)
- DATA_W, 32, result and pc width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  pause when low
- roll_back  input  1  flush on mispredict; synchronous
- alu_valid  input  1  ALU completion offered
- alu_ready  output  1  ALU completion accepted this cycle
- alu_entry  input  ENTRY_W  ROB tag
- alu_result  input  DATA_W  rd value
- alu_pc_result  input  DATA_W  resolved next pc
- ld_valid / ld_ready / ld_entry / ld_result  same as ALU; no pc_result
- st_valid / st_ready / st_entry  store address resolved; tag only
- cdb_valid  output  1  broadcast valid (registered)
- cdb_src  output  2  0=ALU, 1=LOAD, 2=STORE
- cdb_entry  output  ENTRY_W
- cdb_result  output  DATA_W  0 for STORE
- cdb_pc_result  output  DATA_W  0 for LOAD and STORE
- cdb_pending  output  2  number of occupied holding slots (0..3)

## Operation
- One holding slot per source (hold_v, tag, data, pc). A transfer occurs when valid and ready are both high at the clock edge.
- src_ready = rdy_in && !roll_back && (!hold_v || grant_this_source). A slot is refilled in the same cycle that it is granted.
- Arbitration is combinational over hold_v. Round-robin pointer rr ∈ {0,1,2}; search order is rr, rr+1, rr+2 (mod 3). The first occupied slot wins.
- On a grant: the output registers load the slot contents, cdb_valid<=1, the slot clears unless it is refilled the same cycle, and rr<=(winner+1) mod 3.
- No grant: cdb_valid<=0. Other output fields hold their last value.
- An incoming completion is never granted in its arrival cycle. Minimum source-to-cdb latency is 2 edges.
- roll_back: all hold_v<=0, cdb_valid<=0, rr<=0, no accepts; outranks every other event.
- rdy_in low: all state frozen, cdb_valid holds its value, all ready outputs low.
- Reset (asynchronous, any time, including mid-grant): hold_v=0, rr=0, cdb_valid=0, cdb_src=0, cdb_entry=0, cdb_result=0, cdb_pc_result=0, cdb_pending=0.
- cdb_pending is combinational popcount of hold_v.
- Field rules: STORE grant drives cdb_result=0 and cdb_pc_result=0; LOAD grant drives cdb_pc_result=0.

## Timing
- Edge N: source handshake completes and the slot is written.
- Edge N+1: grant at the earliest; cdb_* is visible after edge N+1.
- Throughput is 1 broadcast/cycle aggregate, and 1/cycle per source when uncontested.
- Worst-case wait with all three slots continuously occupied is 2 cycles between grants to a given source (fairness bound).

## Configuration
- CDB_FIXED_PRIORITY_EN defined: fixed priority LOAD > ALU > STORE; rr is not updated and is tied to 0; fairness bound is void.
- CDB_FIXED_PRIORITY_EN undefined: round-robin as specified above.

## Test plan
- Reset release, single ALU offer (entry 5, result 0x11, pc 0x104) -> alu_ready=1; two edges later cdb_valid=1, src=0, entry=5, result=0x11, pc_result=0x104; then cdb_valid=0.
- ALU, LOAD and STORE offered in the same cycle (entries 1, 2, 3), rr=0 -> broadcasts on three consecutive cycles in order 1, 2, 3; cdb_pending goes 3, 2, 1, 0.
- Continuous ALU offers plus one LOAD offer -> LOAD granted within 2 cycles; ALU sustains 1/cycle when uncontested; slot refill on a grant cycle keeps alu_ready=1.
- Slots full, roll_back pulsed -> next edge cdb_valid=0, cdb_pending=0, all ready outputs low during the pulse; next offer after the pulse is broadcast normally with rr=0.
- rdy_in low for 3 cycles with slots occupied -> outputs and pending frozen, ready outputs low; resume without loss or duplication.
- Asynchronous reset asserted between clock edges with cdb_valid=1 -> all outputs 0 immediately, before the next edge. Under CDB_FIXED_PRIORITY_EN, a simultaneous three-way offer -> order LOAD, ALU, STORE.
